// File: rtl/mem_bridge_if.sv
// Bundle of CPU load/store signals and memory-map signals seen by mem_bridge.
// The slave modport is the bridge; master is the CPU plus memory side.
interface mem_bridge_if;
  logic        req;
  logic        wr;
  logic        size32;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  bp_code;
  logic [31:0] rdata;
  logic [31:0] ram_addr;
  logic [15:0] ram_write;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_read;
  logic        ram_ready;
  logic        ram_is_bp;
  logic [15:0] ram_bp_data;

  modport slave (
    input  req, wr, size32, addr, wdata,
    input  ram_read, ram_ready, ram_is_bp, ram_bp_data,
    output busy, done, fault, bp_code, rdata,
    output ram_addr, ram_write, ram_we, ram_re
  );

  modport master (
    output req, wr, size32, addr, wdata,
    output ram_read, ram_ready, ram_is_bp, ram_bp_data,
    input  busy, done, fault, bp_code, rdata,
    input  ram_addr, ram_write, ram_we, ram_re
  );
endinterface

// File: rtl/mem_bridge.sv
// Splits 32-bit CPU accesses into two halfword memory-map transactions,
// sequences the one-cycle read latency and stops on breakpoint hits.
module mem_bridge (
  input  logic         clk,
  input  logic         rst,
  mem_bridge_if.slave  bus_io
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    CAP_LO = 3'd2,
    ACC_HI = 3'd3,
    CAP_HI = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic        size32_q, size32_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  bp_code_q, bp_code_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      size32_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      lo_q      <= 16'd0;
      rdata_q   <= 32'd0;
      fault_q   <= 1'b0;
      bp_code_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size32_q  <= size32_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      bp_code_q <= bp_code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size32_d  = size32_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    bp_code_d = bp_code_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus_io.req) begin
          wr_d     = bus_io.wr;
          size32_d = bus_io.size32;
          addr_d   = bus_io.addr;
          wdata_d  = bus_io.wdata;
          fault_d  = 1'b0;
          state_d  = ACC_LO;
        end else begin
          state_d  = IDLE;
        end
      end
      ACC_LO, ACC_HI: begin
        if (bus_io.ram_ready) begin
          // A store has already been committed by memory in this cycle.
          if (bus_io.ram_is_bp) begin
            fault_d   = 1'b1;
            bp_code_d = bus_io.ram_bp_data[1:0];
            state_d   = DONE;
          end else if (!wr_q) begin
            state_d = (state_q == ACC_LO) ? CAP_LO : CAP_HI;
          end else if (state_q == ACC_LO && size32_q) begin
            state_d = ACC_HI;
          end else begin
            state_d = DONE;
          end
        end
      end
      CAP_LO: begin
        if (bus_io.ram_ready) begin
          lo_d = bus_io.ram_read;
          if (size32_q) begin
            state_d = ACC_HI;
          end else begin
            rdata_d = {16'h0000, bus_io.ram_read};
            state_d = DONE;
          end
        end
      end
      CAP_HI: begin
        if (bus_io.ram_ready) begin
          rdata_d = {bus_io.ram_read, lo_q};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-map outputs are a pure function of state, so a stall holds them.
  always_comb begin
    bus_io.ram_addr  = 32'd0;
    bus_io.ram_write = 16'd0;
    bus_io.ram_we    = 1'b0;
    bus_io.ram_re    = 1'b0;
    case (state_q)
      ACC_LO: begin
        bus_io.ram_addr  = addr_q;
        bus_io.ram_we    = wr_q;
        bus_io.ram_re    = !wr_q;
        bus_io.ram_write = wr_q ? wdata_q[15:0] : 16'd0;
      end
      CAP_LO: begin
        bus_io.ram_addr = addr_q;
        bus_io.ram_re   = 1'b1;
      end
      ACC_HI: begin
        bus_io.ram_addr  = addr_q + 32'd1;
        bus_io.ram_we    = wr_q;
        bus_io.ram_re    = !wr_q;
        bus_io.ram_write = wr_q ? wdata_q[31:16] : 16'd0;
      end
      CAP_HI: begin
        bus_io.ram_addr = addr_q + 32'd1;
        bus_io.ram_re   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_io.busy    = (state_q == ACC_LO) || (state_q == CAP_LO) ||
                          (state_q == ACC_HI) || (state_q == CAP_HI);
  assign bus_io.done    = (state_q == DONE);
  assign bus_io.fault   = fault_q;
  assign bus_io.bp_code = bp_code_q;
  assign bus_io.rdata   = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed and randomized checks of mem_bridge against a transaction-level
// model of memory contents, breakpoints, latency and returned data.
`timescale 1ns/1ps
module tb_mem_bridge;
  logic clk;
  logic rst;
  mem_bridge_if bus ();

  mem_bridge dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-map device: writes on ready, read data one cycle after re.
  logic [15:0] dev_mem [0:255];
  logic [31:0] bp_addr [0:3];
  logic [3:0]  bp_en;

  always @(posedge clk) begin
    if (bus.ram_we && bus.ram_ready) dev_mem[bus.ram_addr[7:0]] <= bus.ram_write;
    if (bus.ram_re) bus.ram_read <= dev_mem[bus.ram_addr[7:0]];
  end

  always_comb begin
    logic hit;
    hit = 1'b0;
    bus.ram_bp_data = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (!hit && bp_en[i] && (bus.ram_we || bus.ram_re) && bus.ram_addr == bp_addr[i]) begin
        hit = 1'b1;
        bus.ram_bp_data = 16'(i);
      end
    end
    bus.ram_is_bp = hit;
  end

  // Reference state.
  logic [15:0] ref_mem [0:255];
  logic [31:0] exp_rdata;
  int checks = 0;
  int errors = 0;
  int tx_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bp_lookup(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (bp_en[i] && bp_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic idle(input int n);
    bus.req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_ram_addr", bus.ram_addr, 32'd0);
      check("idle_ram_en", {30'd0, bus.ram_we, bus.ram_re}, 32'd0);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  // mode: 0 always ready, 1 random ready, 2 ready low in cycles 2..4.
  task automatic access(input logic w, input logic s32, input logic [31:0] a,
                        input logic [31:0] d, input int mode, input logic spam);
    int b0, b1, lat, stalls, k;
    logic [31:0] a1, p_addr;
    logic [15:0] lo, p_write;
    logic [1:0]  p_en, exp_code;
    logic        exp_fault, prev_stall, seen;

    a1 = a + 32'd1;
    b0 = bp_lookup(a);
    b1 = bp_lookup(a1);
    lo = ref_mem[a[7:0]];
    exp_fault = 1'b0;
    exp_code  = 2'd0;
    lat       = 0;
    if (b0 >= 0) begin
      exp_fault = 1'b1;
      exp_code  = 2'(b0);
      lat       = 2;
      if (w) ref_mem[a[7:0]] = d[15:0];
    end else if (w) begin
      ref_mem[a[7:0]] = d[15:0];
      if (!s32) lat = 2;
      else begin
        lat = 3;
        ref_mem[a1[7:0]] = d[31:16];
        if (b1 >= 0) begin exp_fault = 1'b1; exp_code = 2'(b1); end
      end
    end else begin
      if (!s32) begin
        lat = 3;
        exp_rdata = {16'h0000, lo};
      end else if (b1 >= 0) begin
        lat = 4;
        exp_fault = 1'b1;
        exp_code  = 2'(b1);
      end else begin
        lat = 5;
        exp_rdata = {ref_mem[a1[7:0]], lo};
      end
    end

    bus.req = 1'b1; bus.wr = w; bus.size32 = s32; bus.addr = a; bus.wdata = d;
    bus.ram_ready = 1'b1;
    stalls = 0; prev_stall = 1'b0; seen = 1'b0; k = 0;
    p_addr = 32'd0; p_write = 16'd0; p_en = 2'd0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.done) seen = 1'b1;
      else begin
        check("busy", 32'(bus.busy), 32'd1);
        if (prev_stall) begin
          check("hold_addr", bus.ram_addr, p_addr);
          check("hold_ctl", {14'd0, bus.ram_we, bus.ram_re, bus.ram_write},
                {14'd0, p_en, p_write});
        end
        case (mode)
          1:       bus.ram_ready = ($urandom_range(0, 3) != 0);
          2:       bus.ram_ready = !(k >= 2 && k <= 4);
          default: bus.ram_ready = 1'b1;
        endcase
        prev_stall = !bus.ram_ready;
        if (prev_stall) stalls++;
        p_addr = bus.ram_addr; p_write = bus.ram_write; p_en = {bus.ram_we, bus.ram_re};
        if (spam) begin
          bus.req = 1'b1; bus.wr = 1'($urandom_range(0, 1)); bus.size32 = 1'($urandom_range(0, 1));
          bus.addr = $urandom; bus.wdata = $urandom;
        end else bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    bus.ram_ready = 1'b1;
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(k), 32'(lat + stalls));
      check("fault", 32'(bus.fault), 32'(exp_fault));
      if (exp_fault) check("bp_code", 32'(bus.bp_code), 32'(exp_code));
      check("rdata", bus.rdata, exp_rdata);
      check("busy_at_done", 32'(bus.busy), 32'd0);
    end
    tx_n++;
    $display("tx %0d: %s%0d addr=%h wdata=%h cycles=%0d stalls=%0d fault=%0d rdata=%h",
             tx_n, w ? "st" : "ld", s32 ? 32 : 16, a, d, k, stalls, bus.fault, bus.rdata);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size32 = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    bus.ram_ready = 1'b1;
    bp_en = 4'b0000;
    for (int i = 0; i < 4; i++) bp_addr[i] = 32'd0;
    exp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_fault", {29'd0, bus.fault, bus.bp_code}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_ram_addr", bus.ram_addr, 32'd0);
    check("rst_ram_out", {14'd0, bus.ram_we, bus.ram_re, bus.ram_write}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Directed: 16-bit store then load, back to back.
    access(1'b1, 1'b0, 32'hD000_0010, 32'h0000_ABCD, 0, 1'b0);
    access(1'b0, 1'b0, 32'hD000_0010, 32'h0, 0, 1'b0);
    check("tp_ld16", bus.rdata, 32'h0000_ABCD);
    access(1'b1, 1'b1, 32'h1000_0020, 32'h1234_5678, 0, 1'b0);
    access(1'b0, 1'b1, 32'h1000_0020, 32'h0, 0, 1'b0);
    check("tp_ld32", bus.rdata, 32'h1234_5678);

    // Breakpoint 2 on the high half of a 32-bit load.
    bp_en[2] = 1'b1; bp_addr[2] = 32'h1000_0031;
    access(1'b0, 1'b1, 32'h1000_0030, 32'h0, 0, 1'b0);
    idle(1);

    // Stall during CAP_LO of a 16-bit load.
    access(1'b0, 1'b0, 32'hD000_0010, 32'h0, 2, 1'b0);

    // Address wrap on the high half.
    access(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_BEEF, 0, 1'b0);
    access(1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, 1'b0);
    access(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
    idle(1);

    // Prefill the random region, then random traffic with breakpoints.
    for (int i = 0; i < 32; i++)
      access(1'b1, 1'b0, 32'h2000_0040 + 32'(i), {16'h0, 16'($urandom)}, 0, 1'b0);
    bp_en = 4'b1111;
    bp_addr[0] = 32'h2000_0045; bp_addr[1] = 32'h2000_004A; bp_addr[3] = 32'h2000_0050;
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'h2000_0040 + 32'($urandom_range(0, 30)), $urandom, 1,
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(1);

    // Reset during CAP_HI of a 32-bit load.
    bus.req = 1'b1; bus.wr = 1'b0; bus.size32 = 1'b1; bus.addr = 32'h2000_0052; bus.ram_ready = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("mid_rst_fault", {29'd0, bus.fault, bus.bp_code}, 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    check("mid_rst_ram_addr", bus.ram_addr, 32'd0);
    check("mid_rst_ram_out", {14'd0, bus.ram_we, bus.ram_re, bus.ram_write}, 32'd0);
    exp_rdata = 32'd0;
    @(negedge clk);
    check("rst_no_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    idle(2);

    // Normal access after reset, with requests presented while busy.
    access(1'b0, 1'b1, 32'h2000_0054, 32'h0, 0, 1'b1);
    idle(3);
    access(1'b1, 1'b1, 32'h2000_0058, 32'h89AB_CDEF, 1, 1'b1);
    idle(3);

    for (int i = 8'h40; i <= 8'h5F; i++)
      check("mem_region", 32'(dev_mem[i]), 32'(ref_mem[i]));
    check("mem_10", 32'(dev_mem[8'h10]), 32'(ref_mem[8'h10]));
    check("mem_20", 32'(dev_mem[8'h20]), 32'h0000_5678);
    check("mem_21", 32'(dev_mem[8'h21]), 32'h0000_1234);
    check("mem_ff", 32'(dev_mem[8'hFF]), 32'h0000_BEEF);
    check("mem_00", 32'(dev_mem[8'h00]), 32'h0000_CAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bridge.md
# mem_bridge

Bridges the CPU load/store port to the 16-bit memory map (instruction ROM, stack/heap RAM, LCD, page, breakpoint and interrupt registers). It splits 32-bit accesses into two consecutive halfword transactions and sequences the memory's one-cycle synchronous read latency. It also stops an access on a breakpoint hit and reports which breakpoint fired. It sits directly upstream of the memory-map block and drives its addrIn/write/we/re inputs.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  CPU access request; sampled only in IDLE or DONE.
- wr  in  1  1 = store, 0 = load; latched with req.
- size32  in  1  1 = 32-bit access, 0 = 16-bit; latched with req.
- addr  in  32  halfword address; latched with req.
- wdata  in  32  store data; latched with req; bits 15:0 are written first.
- busy  out  1  high from the cycle after acceptance until DONE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = access stopped by a breakpoint.
- bp_code  out  2  valid with done when fault = 1; index of the breakpoint that fired.
- rdata  out  32  load result; updated on done; held until the next done.
- ram_addr  out  32  memory-map address.
- ram_write  out  16  memory-map write data.
- ram_we  out  1  memory-map write enable.
- ram_re  out  1  memory-map read enable.
- ram_read  in  16  memory-map read data; valid one cycle after address and re are presented.
- ram_ready  in  1  memory ready; a phase advances only when this is high.
- ram_is_bp  in  1  breakpoint match on the current access.
- ram_bp_data  in  16  breakpoint index; only bits 1:0 are used.

## Operation
- States: IDLE, ACC_LO, CAP_LO, ACC_HI, CAP_HI, DONE.
- IDLE/DONE + req:
  - latch addr, wdata, wr, size32;
  - clear fault;
  - go to ACC_LO.
- IDLE/DONE without req: go to IDLE.
- ACC_LO:
  - drive ram_addr = A (the latched address), with ram_we = wr and ram_re = !wr;
  - for stores, ram_write = wdata[15:0].
- ACC_LO with ram_ready = 1, in priority order:
  - ram_is_bp = 1 → fault = 1, bp_code = ram_bp_data[1:0], go to DONE. A store in this cycle has already been committed by memory; the remaining half is suppressed.
  - store → ACC_HI if size32, else DONE.
  - load → CAP_LO.
- CAP_LO:
  - hold ram_addr = A and ram_re = 1, because the read mux decodes the live address;
  - on ram_ready, capture ram_read into the low half;
  - go to ACC_HI if size32, else DONE.
- ACC_HI/CAP_HI: same as the LO states, using address A+1 (32-bit wrap: 0xFFFFFFFF+1 = 0x00000000), wdata[31:16], and the high half.
- ram_ready = 0 in any ACC/CAP state: hold the state and all ram_* outputs unchanged.
- DONE:
  - done = 1, busy = 0;
  - rdata = {hi, lo} for 32-bit loads, {16'h0000, lo} for 16-bit loads;
  - rdata is unchanged for stores and faults.
- req while busy: ignored; not queued.
- Outside the ACC/CAP states: ram_we = ram_re = 0 and ram_addr = 0.

## Timing
- Reset (asynchronous): state = IDLE. These outputs become 0 immediately:
  - busy, done, fault, bp_code, rdata;
  - ram_addr, ram_write, ram_we, ram_re.
- Reset mid-access: the in-flight access is dropped with no done; any half already written stays written.
- Latency from the req cycle (cycle 0) to the done cycle, with ram_ready = 1:
  - 16-bit store: 2.
  - 32-bit store: 3.
  - 16-bit load: 3.
  - 32-bit load: 5.
- Each cycle of ram_ready = 0 adds one cycle.
- Back-to-back: req during the DONE cycle is accepted, so the next ACC_LO follows immediately.
- Breakpoint is evaluated in ACC states only.
- Breakpoint on the high half: the low half completes, rdata is not updated, and fault = 1.

## Test plan
- 16-bit store 0xABCD to 0xD0000010, then 16-bit load → store done at cycle 2; load done at cycle 3 with rdata = 0x0000ABCD.
- 32-bit store 0x12345678 to 0x10000020 → ram sees 0x5678 at 0x10000020, then 0x1234 at 0x10000021. A 32-bit load then returns 0x12345678 at cycle 5.
- Breakpoint 2 enabled at 0x10000031; 32-bit load from 0x10000030 → low half read; done with fault = 1, bp_code = 2; rdata keeps its previous value.
- ram_ready held low for 3 cycles during CAP_LO of a 16-bit load → ram_addr/ram_re are stable throughout; done at cycle 6 with the correct data.
- 32-bit store to 0xFFFFFFFF → high half is written to 0x00000000.
- rst asserted in CAP_HI → all outputs are 0 in the same cycle with no done pulse. After release, a new req completes normally; req while busy produces no extra done.
